// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// fixed 34-cycle start-to-done latency with start/busy/done handshake and abort.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op1,
  input  logic [XLEN-1:0]  op2,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result
);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

  state_t              state;
  logic [2:0]          f3_q;
  logic [XLEN-1:0]     op1_q, op2_q, opb;
  logic [2*XLEN-1:0]   opa, acc;
  logic [CNT_W-1:0]    cnt;
  logic                sa, sb;

  logic                is_div, sign1, sign2, neg1, neg2;
  logic [XLEN-1:0]     abs1, abs2;
  logic [XLEN:0]       rem_sh, diff;
  logic                ge;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot, rem, fin_res;

  always_comb begin
    is_div = f3_q[2];
    sign1  = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
    sign2  = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
    neg1   = sign1 && op1_q[XLEN-1];
    neg2   = sign2 && op2_q[XLEN-1];
    abs1   = neg1 ? -op1_q : op1_q;
    abs2   = neg2 ? -op2_q : op2_q;

    // Partial remainder in acc[hi], quotient bits shift into acc[lo], dividend bits come from opa MSB.
    rem_sh = {acc[2*XLEN-1:XLEN], opa[XLEN-1]};
    diff   = rem_sh - {1'b0, opb};
    ge     = ~diff[XLEN];

    prod   = (sa ^ sb) ? -acc : acc;
    quot   = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem    = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    fin_res = '0;
    case (f3_q)
      3'b000:                 fin_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quot;
      default:                fin_res = rem;
    endcase

    if (is_div && (op2_q == '0)) begin
      fin_res = f3_q[1] ? op1_q : '1;
    end else if ((f3_q == 3'b100 || f3_q == 3'b110) &&
                 op1_q == {1'b1, {(XLEN-1){1'b0}}} && op2_q == '1) begin
      fin_res = f3_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      f3_q   <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              f3_q  <= funct3;
              op1_q <= op1;
              op2_q <= op2;
              busy  <= 1'b1;
              state <= PREP;
            end
          end
          PREP: begin
            sa    <= neg1;
            sb    <= neg2;
            opa   <= {{XLEN{1'b0}}, abs1};
            opb   <= abs2;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
          CALC: begin
            if (is_div) begin
              acc[2*XLEN-1:XLEN] <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
              acc[XLEN-1:0]      <= {acc[XLEN-2:0], ge};
              opa                <= opa << 1;
            end else begin
              if (opb[0]) acc <= acc + opa;
              opa <= opa << 1;
              opb <= opb >> 1;
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) state <= FIN;
          end
          default: begin
            result <= fin_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
